udma_ext_per_byte_adapter: RTL and testbench

- Peripheral-clock-domain stage on the external-peripheral side of the uDMA external peripheral channel.
- TX path: consumes 32-bit words popped from the TX dual-clock FIFO output and serialises them into bytes, LSB first, for a byte-wide external peripheral.
- RX path: packs bytes from the peripheral into 32-bit words and pushes them into the RX dual-clock FIFO input.
- Number of bytes per word set by cfg_datasize_i: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.

---
 rtl/udma_ext_per_byte_adapter.sv | 227 ++++++++++++++++++++++
 tb/tb_udma_ext_per_byte_adapter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/udma_ext_per_byte_adapter.sv
// Byte serialiser (TX) and word packer (RX) between the uDMA dual-clock FIFOs and a byte-wide peripheral.
// Optional RX idle-timeout flush of partial words: define UDMA_EXT_PER_RX_TIMEOUT_EN.
module udma_ext_per_byte_adapter #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_clr_i,
  input  logic [1:0]           cfg_datasize_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic [31:0]          tx_word_i,
  input  logic                 tx_word_valid_i,
  output logic                 tx_word_ready_o,
  output logic [7:0]           tx_byte_o,
  output logic                 tx_byte_valid_o,
  input  logic                 tx_byte_ready_i,
  input  logic [7:0]           rx_byte_i,
  input  logic                 rx_byte_valid_i,
  output logic                 rx_byte_ready_o,
  output logic [31:0]          rx_word_o,
  output logic                 rx_word_valid_o,
  input  logic                 rx_word_ready_i,
  output logic [2:0]           rx_word_bytes_o,
  output logic                 busy_o
);

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_FILL = 1'b0,
    RX_OUT  = 1'b1
  } rx_state_e;

  function automatic logic [2:0] bytes_per_word(input logic [1:0] ds);
    logic [2:0] n;
    case (ds)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_shreg_q, tx_shreg_d;
  logic [2:0]  tx_cnt_q,   tx_cnt_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] rx_pack_q,  rx_pack_d;
  logic [2:0]  rx_idx_q,   rx_idx_d;
  logic [2:0]  rx_n_q,     rx_n_d;
  logic [2:0]  rx_bytes_q, rx_bytes_d;
  logic [2:0]  rx_n_eff_s;
  logic        rx_byte_xfer_s;

`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] rx_tmo_q, rx_tmo_d;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^cfg_timeout_i;
`endif

  // Handshake outputs are pure functions of state; clear forces them low in its own cycle.
  assign tx_word_ready_o = (tx_state_q == TX_IDLE)  && cfg_en_i && !cfg_clr_i;
  assign tx_byte_valid_o = (tx_state_q == TX_SHIFT) && !cfg_clr_i;
  assign tx_byte_o       = tx_shreg_q[7:0];
  assign rx_byte_ready_o = (rx_state_q == RX_FILL)  && cfg_en_i && !cfg_clr_i;
  assign rx_word_valid_o = (rx_state_q == RX_OUT)   && !cfg_clr_i;
  assign rx_word_o       = rx_pack_q;
  assign rx_word_bytes_o = rx_bytes_q;
  assign busy_o          = (tx_state_q != TX_IDLE) || (rx_state_q == RX_OUT) || (rx_idx_q != 3'd0);

  assign rx_byte_xfer_s  = rx_byte_ready_o && rx_byte_valid_i;
  // Word length is sampled on the first byte and frozen for the rest of the word.
  assign rx_n_eff_s      = (rx_idx_q == 3'd0) ? bytes_per_word(cfg_datasize_i) : rx_n_q;

  // TX next-state: load a word in idle, shift out one byte per accepted transfer.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shreg_d = tx_shreg_q;
    tx_cnt_d   = tx_cnt_q;
    if (cfg_clr_i) begin
      tx_state_d = TX_IDLE;
      tx_shreg_d = 32'h0000_0000;
      tx_cnt_d   = 3'd0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (cfg_en_i && tx_word_valid_i) begin
            tx_state_d = TX_SHIFT;
            tx_shreg_d = tx_word_i;
            tx_cnt_d   = bytes_per_word(cfg_datasize_i);
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
        TX_SHIFT: begin
          if (tx_byte_ready_i) begin
            if (tx_cnt_q == 3'd1) begin
              tx_state_d = TX_IDLE;
              tx_shreg_d = 32'h0000_0000;
              tx_cnt_d   = 3'd0;
            end else begin
              tx_shreg_d = {8'h00, tx_shreg_q[31:8]};
              tx_cnt_d   = tx_cnt_q - 3'd1;
            end
          end else begin
            tx_state_d = TX_SHIFT;
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          tx_shreg_d = 32'h0000_0000;
          tx_cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // RX next-state: pack bytes into lanes, present the word, optionally flush on idle timeout.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_pack_d  = rx_pack_q;
    rx_idx_d   = rx_idx_q;
    rx_n_d     = rx_n_q;
    rx_bytes_d = rx_bytes_q;
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
    rx_tmo_d   = rx_tmo_q;
`endif
    if (cfg_clr_i) begin
      rx_state_d = RX_FILL;
      rx_pack_d  = 32'h0000_0000;
      rx_idx_d   = 3'd0;
      rx_n_d     = 3'd0;
      rx_bytes_d = 3'd0;
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
      rx_tmo_d   = '0;
`endif
    end else begin
      case (rx_state_q)
        RX_FILL: begin
          if (rx_byte_xfer_s) begin
            rx_pack_d[{rx_idx_q[1:0], 3'b000} +: 8] = rx_byte_i;
            rx_idx_d = rx_idx_q + 3'd1;
            rx_n_d   = rx_n_eff_s;
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
            rx_tmo_d = '0;
`endif
            if (rx_idx_q == (rx_n_eff_s - 3'd1)) begin
              rx_state_d = RX_OUT;
              rx_bytes_d = rx_n_eff_s;
            end else begin
              rx_state_d = RX_FILL;
            end
          end else begin
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
            // A byte arriving on the expiry cycle wins because it takes the branch above.
            if ((rx_idx_q != 3'd0) && (cfg_timeout_i != '0)) begin
              if (rx_tmo_q == cfg_timeout_i) begin
                rx_state_d = RX_OUT;
                rx_bytes_d = rx_idx_q;
                rx_tmo_d   = '0;
              end else begin
                rx_tmo_d   = rx_tmo_q + TIMEOUT_W'(1);
              end
            end else begin
              rx_tmo_d = '0;
            end
`else
            rx_state_d = RX_FILL;
`endif
          end
        end
        RX_OUT: begin
          if (rx_word_ready_i) begin
            rx_state_d = RX_FILL;
            rx_pack_d  = 32'h0000_0000;
            rx_idx_d   = 3'd0;
            rx_bytes_d = 3'd0;
          end else begin
            rx_state_d = RX_OUT;
          end
        end
        default: begin
          rx_state_d = RX_FILL;
          rx_pack_d  = 32'h0000_0000;
          rx_idx_d   = 3'd0;
          rx_bytes_d = 3'd0;
        end
      endcase
    end
  end

  // State and datapath registers for both paths.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state_q <= TX_IDLE;
      tx_shreg_q <= 32'h0000_0000;
      tx_cnt_q   <= 3'd0;
      rx_state_q <= RX_FILL;
      rx_pack_q  <= 32'h0000_0000;
      rx_idx_q   <= 3'd0;
      rx_n_q     <= 3'd0;
      rx_bytes_q <= 3'd0;
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
      rx_tmo_q   <= '0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shreg_q <= tx_shreg_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_state_q <= rx_state_d;
      rx_pack_q  <= rx_pack_d;
      rx_idx_q   <= rx_idx_d;
      rx_n_q     <= rx_n_d;
      rx_bytes_q <= rx_bytes_d;
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
      rx_tmo_q   <= rx_tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_udma_ext_per_byte_adapter.sv
// Directed self-checking bench for udma_ext_per_byte_adapter (TX serialiser, RX packer, clear, timeout).
module tb_udma_ext_per_byte_adapter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i, cfg_clr_i;
  logic [1:0]  cfg_datasize_i;
  logic [7:0]  cfg_timeout_i;
  logic [31:0] tx_word_i;
  logic        tx_word_valid_i, tx_word_ready_o;
  logic [7:0]  tx_byte_o;
  logic        tx_byte_valid_o, tx_byte_ready_i;
  logic [7:0]  rx_byte_i;
  logic        rx_byte_valid_i, rx_byte_ready_o;
  logic [31:0] rx_word_o;
  logic        rx_word_valid_o, rx_word_ready_i;
  logic [2:0]  rx_word_bytes_o;
  logic        busy_o;

  int n_total = 0;
  int n_pass  = 0;

  udma_ext_per_byte_adapter #(.TIMEOUT_W(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_timeout_i(cfg_timeout_i),
    .tx_word_i(tx_word_i), .tx_word_valid_i(tx_word_valid_i), .tx_word_ready_o(tx_word_ready_o),
    .tx_byte_o(tx_byte_o), .tx_byte_valid_o(tx_byte_valid_o), .tx_byte_ready_i(tx_byte_ready_i),
    .rx_byte_i(rx_byte_i), .rx_byte_valid_i(rx_byte_valid_i), .rx_byte_ready_o(rx_byte_ready_o),
    .rx_word_o(rx_word_o), .rx_word_valid_o(rx_word_valid_o), .rx_word_ready_i(rx_word_ready_i),
    .rx_word_bytes_o(rx_word_bytes_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] w;
  logic [31:0] cap_word;
  logic [2:0]  cap_bytes;
  logic        found;

  initial begin
    rstn_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0; cfg_datasize_i = 2'd0; cfg_timeout_i = 8'd0;
    tx_word_i = 32'h0; tx_word_valid_i = 1'b0; tx_byte_ready_i = 1'b0;
    rx_byte_i = 8'h0; rx_byte_valid_i = 1'b0; rx_word_ready_i = 1'b0;
    #12;
    check("rst_outs", {tx_word_ready_o, tx_byte_valid_o, rx_byte_ready_o, rx_word_valid_o, busy_o, rx_word_bytes_o}, 32'h0);
    check("rst_tx_byte", {24'h0, tx_byte_o}, 32'h0);
    check("rst_rx_word", rx_word_o, 32'h0);
    rstn_i = 1'b1;

    // TX, 4 bytes per word, peripheral always ready
    tick; cfg_en_i = 1'b1; cfg_datasize_i = 2'd2; w = 32'h4433_2211;
    tx_word_i = w; tx_word_valid_i = 1'b1; tx_byte_ready_i = 1'b1; #1;
    check("tx1_wrdy_idle", {31'h0, tx_word_ready_o}, 32'h1);
    tick; tx_word_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tx1_bvalid", {31'h0, tx_byte_valid_o}, 32'h1);
      check("tx1_byte", {24'h0, tx_byte_o}, {24'h0, w[8*k +: 8]});
      check("tx1_wrdy_busy", {31'h0, tx_word_ready_o}, 32'h0);
      tick;
    end
    #1;
    check("tx1_done_bvalid", {31'h0, tx_byte_valid_o}, 32'h0);
    check("tx1_done_wrdy", {31'h0, tx_word_ready_o}, 32'h1);

    // TX, 2 bytes per word, peripheral ready toggling
    tick; cfg_datasize_i = 2'd1; tx_word_i = 32'hAABB_CCDD; tx_word_valid_i = 1'b1; tx_byte_ready_i = 1'b0; #1;
    check("tx2_wrdy", {31'h0, tx_word_ready_o}, 32'h1);
    tick; tx_word_valid_i = 1'b0; tx_word_i = 32'h0; #1;
    check("tx2_b0_wait", {23'h0, tx_byte_valid_o, tx_byte_o}, 32'h1DD);
    tick; tx_byte_ready_i = 1'b1; #1;
    check("tx2_b0_stable", {23'h0, tx_byte_valid_o, tx_byte_o}, 32'h1DD);
    tick; tx_byte_ready_i = 1'b0; #1;
    check("tx2_b1_wait", {23'h0, tx_byte_valid_o, tx_byte_o}, 32'h1CC);
    tick; tx_byte_ready_i = 1'b1; #1;
    check("tx2_b1_stable", {23'h0, tx_byte_valid_o, tx_byte_o}, 32'h1CC);
    for (int k = 0; k < 4; k++) begin
      tick; tx_byte_ready_i = ~tx_byte_ready_i; #1;
      check("tx2_no_extra", {31'h0, tx_byte_valid_o}, 32'h0);
    end
    tx_byte_ready_i = 1'b1;

    // RX, 1 byte per word, then downstream backpressure
    tick; cfg_datasize_i = 2'd0; rx_word_ready_i = 1'b1; rx_byte_i = 8'h5A; rx_byte_valid_i = 1'b1; #1;
    check("rx1_brdy", {31'h0, rx_byte_ready_o}, 32'h1);
    tick; rx_byte_i = 8'hA5; #1;
    check("rx1_w0", {rx_word_valid_o, rx_byte_ready_o, 27'h0, rx_word_bytes_o}, {2'b10, 27'h0, 3'd1});
    check("rx1_w0_data", rx_word_o, 32'h0000_005A);
    tick; #1;
    check("rx1_refill", {30'h0, rx_byte_ready_o, rx_word_valid_o}, 32'h2);
    tick; rx_byte_valid_i = 1'b0; rx_word_ready_i = 1'b0; #1;
    check("rx1_w1", {rx_word_valid_o, 28'h0, rx_word_bytes_o}, {1'b1, 28'h0, 3'd1});
    check("rx1_w1_data", rx_word_o, 32'h0000_00A5);
    for (int k = 0; k < 3; k++) begin
      tick; rx_byte_i = 8'hEE; rx_byte_valid_i = 1'b1; #1;
      check("rx1_hold_brdy", {31'h0, rx_byte_ready_o}, 32'h0);
      check("rx1_hold_word", {rx_word_valid_o, rx_word_o[30:0]}, {1'b1, 31'h0000_00A5});
    end
    tick; rx_byte_valid_i = 1'b0; rx_word_ready_i = 1'b1;
    tick; #1;
    check("rx1_drained", {30'h0, rx_word_valid_o, busy_o}, 32'h0);

    // RX, 4 bytes per word; datasize change mid-word is ignored
    tick; cfg_datasize_i = 2'd2; rx_byte_i = 8'h01; rx_byte_valid_i = 1'b1;
    tick; cfg_datasize_i = 2'd0; rx_byte_i = 8'h02;
    tick; rx_byte_i = 8'h03;
    tick; rx_byte_i = 8'h04; #1;
    check("rx2_not_yet", {31'h0, rx_word_valid_o}, 32'h0);
    tick; rx_byte_valid_i = 1'b0; #1;
    check("rx2_word", rx_word_o, 32'h0403_0201);
    check("rx2_bytes", {28'h0, rx_word_valid_o, rx_word_bytes_o}, {28'h0, 1'b1, 3'd4});
    tick; cfg_datasize_i = 2'd2; #1;
    check("rx2_drained", {31'h0, rx_word_valid_o}, 32'h0);

    // Clear mid RX word and mid TX word
    tick; tx_word_i = 32'hDEAD_BEEF; tx_word_valid_i = 1'b1; tx_byte_ready_i = 1'b0;
    rx_byte_i = 8'hE0; rx_byte_valid_i = 1'b1;
    tick; tx_word_valid_i = 1'b0; rx_byte_i = 8'hE1;
    tick; rx_byte_valid_i = 1'b0; #1;
    check("clr_pre", {22'h0, busy_o, tx_byte_valid_o, tx_byte_o}, 32'h3EF);
    tick; cfg_clr_i = 1'b1; tx_byte_ready_i = 1'b1; rx_byte_i = 8'hE2; rx_byte_valid_i = 1'b1; #1;
    check("clr_hs_low", {29'h0, tx_byte_valid_o, rx_byte_ready_o, tx_word_ready_o}, 32'h0);
    tick; cfg_clr_i = 1'b0; rx_byte_valid_i = 1'b0; #1;
    check("clr_post", {30'h0, busy_o, tx_byte_valid_o}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rx_byte_i = 8'(8'h10 + i); rx_byte_valid_i = 1'b1;
      tick;
      check("clr_no_stale_tx", {31'h0, tx_byte_valid_o}, 32'h0);
    end
    rx_byte_valid_i = 1'b0; #1;
    check("clr_rx_word", rx_word_o, 32'h1312_1110);
    check("clr_rx_bytes", {28'h0, rx_word_valid_o, rx_word_bytes_o}, {28'h0, 1'b1, 3'd4});
    tick;

    // Idle timeout: cfg_timeout_i = 5, two bytes then idle
    tick; cfg_timeout_i = 8'd5; rx_byte_i = 8'h77; rx_byte_valid_i = 1'b1;
    tick; rx_byte_i = 8'h88;
    tick; rx_byte_valid_i = 1'b0;
    found = 1'b0; cap_word = 32'h0; cap_bytes = 3'd0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rx_word_valid_o && !found) begin
        found = 1'b1; cap_word = rx_word_o; cap_bytes = rx_word_bytes_o;
      end
    end
`ifdef UDMA_EXT_PER_RX_TIMEOUT_EN
    check("tmo_flush_seen", {31'h0, found}, 32'h1);
    check("tmo_flush_word", cap_word, 32'h0000_8877);
    check("tmo_flush_bytes", {29'h0, cap_bytes}, 32'h2);
`else
    check("tmo_ignored", {31'h0, found}, 32'h0);
`endif

    // Same stimulus with timeout disabled: the partial word must stay pending
    tick; cfg_clr_i = 1'b1;
    tick; cfg_clr_i = 1'b0; cfg_timeout_i = 8'd0; rx_byte_i = 8'h77; rx_byte_valid_i = 1'b1;
    tick; rx_byte_i = 8'h88;
    tick; rx_byte_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rx_word_valid_o) found = 1'b1;
    end
    check("tmo_off_no_word", {31'h0, found}, 32'h0);
    check("tmo_off_busy", {31'h0, busy_o}, 32'h1);
    tick; cfg_clr_i = 1'b1;
    tick; cfg_clr_i = 1'b0; #1;
    check("final_idle", {31'h0, busy_o}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
